mcu_multi_cycle: RTL

MCU_MULTI_CYCLE -- requirements
Module: mcu_multi_cycle

---
 rtl/mcu_multi_cycle.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mcu_multi_cycle.sv
// Multi-cycle microcontroller core: FETCH/DECODE/EXEC/MEM/WB sequencer with
// req/ack instruction and data ports, a 16-entry register file and a retire counter.
module mcu_multi_cycle #(
  parameter int unsigned     DATA_W   = 16,
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic              clk,
  input  logic              nClear,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  input  logic [3:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [15:0]       instr_out,
  output logic [PC_W-1:0]   pc_out,
  output logic              halted,
  output logic [2:0]        state_out,
  output logic [31:0]       retired
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hA;

  localparam logic [PC_W-1:0]   PC_ONE    = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  state_t              state_r;
  logic [PC_W-1:0]     pc_r;
  logic [15:0]         ir_r;
  logic [DATA_W-1:0]   a_r;
  logic [DATA_W-1:0]   b_r;
  logic [DATA_W-1:0]   res_r;
  logic [DATA_W-1:0]   addr_r;
  logic [DATA_W-1:0]   rf_r [16];
  logic [31:0]         retired_r;
  logic                halted_r;
  logic                imem_req_r;
  logic                dmem_req_r;
  logic                dmem_we_r;

  logic [3:0]          op_s;
  logic [3:0]          rs_s;
  logic [3:0]          rt_s;
  logic [3:0]          rd_s;
  logic [3:0]          wb_idx_s;
  logic [DATA_W-1:0]   imm_d_s;
  logic [PC_W-1:0]     imm_p_s;
  logic [DATA_W-1:0]   alu_s;

  // Field decode and ALU; LW/SW/ADDI share the A+imm adder through the default arm.
  always_comb begin
    op_s     = ir_r[15:12];
    rs_s     = ir_r[11:8];
    rt_s     = ir_r[7:4];
    rd_s     = ir_r[3:0];
    imm_d_s  = {{(DATA_W-4){ir_r[3]}}, ir_r[3:0]};
    imm_p_s  = {{(PC_W-4){ir_r[3]}}, ir_r[3:0]};
    wb_idx_s = ((op_s == OP_ADDI) || (op_s == OP_LW)) ? rt_s : rd_s;
    alu_s    = a_r + imm_d_s;
    case (op_s)
      OP_ADD:  alu_s = a_r + b_r;
      OP_SUB:  alu_s = a_r - b_r;
      OP_AND:  alu_s = a_r & b_r;
      OP_OR:   alu_s = a_r | b_r;
      OP_SLT:  alu_s = ($signed(a_r) < $signed(b_r)) ? DATA_ONE : DATA_ZERO;
      default: alu_s = a_r + imm_d_s;
    endcase
  end

  // Sequencer, datapath registers and register file.
  always_ff @(posedge clk or negedge nClear) begin
    if (!nClear) begin
      state_r    <= ST_FETCH;
      pc_r       <= RESET_PC;
      ir_r       <= 16'h0000;
      a_r        <= DATA_ZERO;
      b_r        <= DATA_ZERO;
      res_r      <= DATA_ZERO;
      addr_r     <= DATA_ZERO;
      retired_r  <= 32'd0;
      halted_r   <= 1'b0;
      imem_req_r <= 1'b0;
      dmem_req_r <= 1'b0;
      dmem_we_r  <= 1'b0;
      for (int i = 0; i < 16; i++) rf_r[i] <= DATA_ZERO;
    end else begin
      case (state_r)
        ST_FETCH: begin
          // Request rises one cycle after reset release; an ack seen while req is low is ignored.
          if (imem_req_r && imem_ack) begin
            ir_r       <= imem_rdata;
            pc_r       <= pc_r + PC_ONE;
            imem_req_r <= 1'b0;
            state_r    <= ST_DECODE;
          end else begin
            imem_req_r <= 1'b1;
          end
        end
        ST_DECODE: begin
          a_r     <= rf_r[rs_s];
          b_r     <= rf_r[rt_s];
          state_r <= ST_DECODE == ST_DECODE ? ST_EXEC : ST_EXEC;
        end
        ST_EXEC: begin
          res_r  <= alu_s;
          addr_r <= alu_s;
          case (op_s)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI: state_r <= ST_WB;
            OP_LW, OP_SW: begin
              dmem_req_r <= 1'b1;
              dmem_we_r  <= (op_s == OP_SW);
              state_r    <= ST_MEM;
            end
            OP_HALT: begin
              halted_r  <= 1'b1;
              retired_r <= retired_r + 32'd1;
              state_r   <= ST_HALT;
            end
            default: begin
              if (op_s == OP_BEQ) begin
                if (a_r == b_r) pc_r <= pc_r + imm_p_s;
              end else if (op_s == OP_JMP) begin
                pc_r <= {pc_r[PC_W-1:12], ir_r[11:0]};
              end
              imem_req_r <= 1'b1;
              retired_r  <= retired_r + 32'd1;
              state_r    <= ST_FETCH;
            end
          endcase
        end
        ST_MEM: begin
          if (dmem_req_r && dmem_ack) begin
            dmem_req_r <= 1'b0;
            dmem_we_r  <= 1'b0;
            if (op_s == OP_LW) begin
              res_r   <= dmem_rdata;
              state_r <= ST_WB;
            end else begin
              imem_req_r <= 1'b1;
              retired_r  <= retired_r + 32'd1;
              state_r    <= ST_FETCH;
            end
          end
        end
        ST_WB: begin
          if (wb_idx_s != 4'd0) rf_r[wb_idx_s] <= res_r;
          imem_req_r <= 1'b1;
          retired_r  <= retired_r + 32'd1;
          state_r    <= ST_FETCH;
        end
        ST_HALT: state_r <= ST_HALT;
        default: begin
          imem_req_r <= 1'b0;
          dmem_req_r <= 1'b0;
          dmem_we_r  <= 1'b0;
          state_r    <= ST_FETCH;
        end
      endcase
    end
  end

  assign imem_req   = imem_req_r;
  assign imem_addr  = pc_r;
  assign dmem_req   = dmem_req_r;
  assign dmem_we    = dmem_we_r;
  assign dmem_addr  = addr_r;
  assign dmem_wdata = b_r;
  assign dbg_rdata  = (dbg_raddr == 4'd0) ? DATA_ZERO : rf_r[dbg_raddr];
  assign instr_out  = ir_r;
  assign pc_out     = pc_r;
  assign halted     = halted_r;
  assign state_out  = state_r;
  assign retired    = retired_r;

endmodule
